layer_compositor: RTL
=====================

# layer_compositor

Parametrised pixel compositor that merges a background and NUM_LAYERS sprite layers into the final VGA RGB stream. It runs on the pixel clock, between the sprite/background ROM readers and the VGA DAC pins. It adds four things: a runtime priority order latched per frame, a colour-key transparency test, per-layer hit-flash timers, and a round-end fade-to-black sequencer. Output is registered with a fixed 2-cycle latency.

## Interface
Parameters:
- NUM_LAYERS, default 4: number of sprite layers (2..8).
- COLOR_W, default 4: bits per colour channel.
- FLASH_FRAMES, default 8: frames a layer flashes after a hit.
- FADE_STEP, default 4: frames per fade level step.
- IDX_W, default $clog2(NUM_LAYERS): layer index width.

Ports:
- vga_clk  in  1  pixel clock; only clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- blank  in  1  1 = active video, 0 = blanking.
- bg_rgb  in  3*COLOR_W  background pixel {R,G,B}.
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  per-layer pixel; layer i at slice i.
- layer_on  in  NUM_LAYERS  layer i covers the current pixel.
- layer_en  in  NUM_LAYERS  layer i globally enabled.
- key_rgb  in  3*COLOR_W  transparent colour, shared by all layers.
- prio_map  in  NUM_LAYERS*IDX_W  slot s holds a layer index; slot 0 is highest priority.
- hit  in  NUM_LAYERS  one-cycle pulse that starts a flash on layer i.
- fade_req, fade_clear  in  1  pulses that start and cancel the fade.
- Red, Green, Blue  out  COLOR_W  composited pixel.
- blank_out  out  1  blank delayed to match the pixel.
- fade_done  out  1  high while the screen is fully faded.

## Operation
- Visibility rule: layer i is visible when layer_on[i] & layer_en[i] & (layer_rgb[i] != key_rgb).
- Priority latch: prio_map is copied into a shadow register only on frame_start. This prevents mid-frame tearing.
- Shadow reset value is the identity map: slot s = layer s.
- Duplicate indices in the shadow: the lowest slot wins.
- A layer absent from the shadow map is never drawn.
- Stage 1 selection:
  - Pick the layer in the lowest-numbered slot that is visible.
  - If no layer is visible, pick bg_rgb.
  - Register the colour, a valid flag and the winning layer index.
- Flash timers, one per layer:
  - hit[i] loads the counter with FLASH_FRAMES.
  - frame_start decrements a nonzero counter.
  - If hit[i] and frame_start occur in the same cycle, the load wins.
  - A hit while the counter is nonzero retriggers it (reloads FLASH_FRAMES).
  - Flash is active when the counter is nonzero and its bit0 = 1.
- Stage 2 flash: if the winning layer's flash is active, the colour is replaced by all-ones (white). Background never flashes.
- Fade FSM states:
  - FADE_IDLE: level = 0. fade_req moves to FADE_OUT.
  - FADE_OUT: level increments once every FADE_STEP frame_starts. Reaching 2^COLOR_W-1 moves to FADE_HOLD.
  - FADE_HOLD: level held; fade_done = 1.
  - fade_clear from any state moves to FADE_IDLE and sets level = 0. If fade_req and fade_clear arrive together, fade_clear wins.
  - fade_req in FADE_OUT or FADE_HOLD is ignored.
- Stage 2 fade: each channel = max(channel - level, 0), a saturating COLOR_W-bit subtract. Fade is applied after flash.
- Blanking: when the delayed blank is 0, Red, Green and Blue are forced to 0.

## Timing
- Reset values:
  - Red, Green, Blue, blank_out, fade_done = 0.
  - Flash counters = 0, fade level = 0, FSM = FADE_IDLE, frame divider = 0, shadow map = identity.
- Latency: pixel inputs at cycle n appear on the outputs at cycle n+2. blank_out is blank delayed by 2 cycles.
- Control inputs take effect on the cycle after they are sampled:
  - A hit at cycle n affects pixels entering Stage 2 at n+1.
  - A shadow map latched on frame_start applies to pixels entering Stage 1 on the next cycle.
- fade_done rises in the cycle after the FSM enters FADE_HOLD.
- Fade frame divider: 0..FADE_STEP-1, counts frame_start pulses only while in FADE_OUT, and is cleared when FADE_OUT is entered.
- Reset mid-frame: all state clears immediately and the outputs drive black.

## Structure
- Package compositor_pkg holds:
  - typedef rgb_t, a packed struct {r,g,b} of COLOR_W bits each;
  - enum fade_state_t {FADE_IDLE, FADE_OUT, FADE_HOLD};
  - the WHITE constant;
  - the function sat_sub.
- Sub-module flash_timer: one per layer via generate. Ports: vga_clk, reset_n, hit, frame_start, active.
- The top level contains the shadow register, the selection logic, both pipeline stages and the fade FSM.

## Test plan
- Priority: layers 0 and 1 both visible, prio_map = {1,0} latched at frame_start → output = layer1 colour at n+2. Change prio_map mid-frame with no frame_start → output is unchanged.
- Transparency: layer0 rgb = key_rgb = 12'hF0F with layer_on = 1 → output = bg_rgb. Set layer_en = 0 on an opaque pixel → output = bg_rgb.
- Flash: hit[0], then 8 frame_starts → layer0 pixels are white on frames where the counter is odd and normal on even frames; the counter reaches 0 after 8 frames. Assert hit and frame_start together → the counter reloads to 8.
- Fade: fade_req with FADE_STEP = 4 → level 1 after 4 frames; a pixel of 4'h3 reads 4'h0 once level ≥ 3; fade_done = 1 after 60 frames. A fade_clear pulse → level 0 and fade_done = 0 on the next cycle.
- Blank and latency: random pixel stream with blank toggling → outputs equal the reference model delayed 2 cycles; outputs are 0 whenever blank_out = 0.
- Reset: assert reset_n low mid-fade and mid-flash → all outputs 0 immediately; after release the identity priority map is in effect.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// compositor_pkg: shared pixel types, fade states and colour helpers for layer_compositor.
`default_nettype none

package compositor_pkg;

  localparam int PKG_COLOR_W = 4;
  localparam int SUB_W       = 8;

  typedef struct packed {
    logic [PKG_COLOR_W-1:0] r;
    logic [PKG_COLOR_W-1:0] g;
    logic [PKG_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_OUT  = 2'd1,
    FADE_HOLD = 2'd2
  } fade_state_t;

  localparam rgb_t WHITE = '{r: '1, g: '1, b: '1};

  // Saturating subtract; channels up to SUB_W bits are zero-extended by the caller.
  function automatic logic [SUB_W-1:0] sat_sub(input logic [SUB_W-1:0] a,
                                               input logic [SUB_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_compositor_flash_timer.sv
// flash_timer: per-layer hit-flash frame counter; active on odd nonzero counts.
`default_nettype none

module flash_timer #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic hit,
  input  logic frame_start,
  output logic active
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(FLASH_FRAMES);

  logic [CNT_W-1:0] count;

  // A hit reloads even when it coincides with a frame tick.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (hit) begin
      count <= LOAD;
    end else if (frame_start && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign active = count[0];

endmodule

`default_nettype wire

// File: rtl/layer_compositor.sv
// layer_compositor: prioritised sprite/background merge with colour key, hit flash
// and fade-to-black, two registered stages from pixel inputs to the VGA pins.
`default_nettype none

module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int FADE_STEP    = 4,
  parameter int IDX_W        = $clog2(NUM_LAYERS)
) (
  input  logic                            vga_clk,
  input  logic                            reset_n,
  input  logic                            frame_start,
  input  logic                            blank,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]           layer_on,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  input  logic [3*COLOR_W-1:0]            key_rgb,
  input  logic [NUM_LAYERS*IDX_W-1:0]     prio_map,
  input  logic [NUM_LAYERS-1:0]           hit,
  input  logic                            fade_req,
  input  logic                            fade_clear,
  output logic [COLOR_W-1:0]              Red,
  output logic [COLOR_W-1:0]              Green,
  output logic [COLOR_W-1:0]              Blue,
  output logic                            blank_out,
  output logic                            fade_done
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int DIV_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FADE_STEP - 1);
  localparam logic [COLOR_W-1:0] LEVEL_PRE  = {{(COLOR_W-1){1'b1}}, 1'b0};

  logic [NUM_LAYERS*IDX_W-1:0] shadow;
  logic [NUM_LAYERS-1:0]       visible;
  logic [NUM_LAYERS-1:0]       flash_active;
  logic [PIX_W-1:0]            white_px;

  logic [IDX_W-1:0]            slot_idx;
  logic [PIX_W-1:0]            sel_rgb;
  logic                        sel_valid;
  logic [IDX_W-1:0]            sel_idx;

  logic [PIX_W-1:0]            s1_rgb;
  logic                        s1_valid;
  logic [IDX_W-1:0]            s1_idx;
  logic                        s1_blank;

  logic [PIX_W-1:0]            flashed;
  logic [PIX_W-1:0]            faded;
  logic [SUB_W-1:0]            chan;

  fade_state_t                 state;
  fade_state_t                 state_nxt;
  logic [COLOR_W-1:0]          level;
  logic [COLOR_W-1:0]          level_nxt;
  logic [DIV_W-1:0]            div;
  logic [DIV_W-1:0]            div_nxt;
  logic                        fade_done_nxt;

  if (COLOR_W == PKG_COLOR_W) begin : g_white_pkg
    assign white_px = WHITE;
  end else begin : g_white_gen
    assign white_px = {PIX_W{1'b1}};
  end

  // Priority order only changes at frame boundaries so a frame never tears.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_LAYERS; s++) begin
        shadow[s*IDX_W +: IDX_W] <= IDX_W'(s);
      end
    end else if (frame_start) begin
      shadow <= prio_map;
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_vis
    assign visible[i] = layer_on[i] & layer_en[i] &
                        (layer_rgb[i*PIX_W +: PIX_W] != key_rgb);
  end

  // Walk slots from lowest priority up so the lowest visible slot is the last writer.
  always_comb begin
    slot_idx  = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_rgb   = bg_rgb;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      slot_idx = shadow[s*IDX_W +: IDX_W];
      if ((int'(slot_idx) < NUM_LAYERS) && visible[slot_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = slot_idx;
      end
    end
    if (sel_valid) begin
      sel_rgb = layer_rgb[sel_idx*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_rgb   <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_blank <= 1'b0;
    end else begin
      s1_rgb   <= sel_rgb;
      s1_valid <= sel_valid;
      s1_idx   <= sel_idx;
      s1_blank <= blank;
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_flash
    flash_timer #(
      .FLASH_FRAMES(FLASH_FRAMES)
    ) u_flash (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .hit        (hit[i]),
      .frame_start(frame_start),
      .active     (flash_active[i])
    );
  end

  // Flash first, then fade, so a flashing sprite still darkens with the screen.
  always_comb begin
    flashed = (s1_valid && flash_active[s1_idx]) ? white_px : s1_rgb;
    faded   = '0;
    chan    = '0;
    for (int c = 0; c < 3; c++) begin
      chan = sat_sub(SUB_W'(flashed[c*COLOR_W +: COLOR_W]), SUB_W'(level));
      faded[c*COLOR_W +: COLOR_W] = chan[COLOR_W-1:0];
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      blank_out <= 1'b0;
    end else begin
      Red       <= s1_blank ? faded[2*COLOR_W +: COLOR_W] : '0;
      Green     <= s1_blank ? faded[1*COLOR_W +: COLOR_W] : '0;
      Blue      <= s1_blank ? faded[0*COLOR_W +: COLOR_W] : '0;
      blank_out <= s1_blank;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FADE_IDLE;
      level     <= '0;
      div       <= '0;
      fade_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      div       <= div_nxt;
      fade_done <= fade_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FADE_IDLE: if (fade_req) state_nxt = FADE_OUT;
      FADE_OUT:  if (frame_start && (div == DIV_LAST) && (level == LEVEL_PRE))
                   state_nxt = FADE_HOLD;
      FADE_HOLD: state_nxt = FADE_HOLD;
      default:   state_nxt = FADE_IDLE;
    endcase
    if (fade_clear) state_nxt = FADE_IDLE;
  end

  always_comb begin
    level_nxt     = level;
    div_nxt       = div;
    fade_done_nxt = (state == FADE_HOLD) && !fade_clear;
    if (fade_clear || (state == FADE_IDLE)) begin
      level_nxt = '0;
      div_nxt   = '0;
    end else if ((state == FADE_OUT) && frame_start) begin
      if (div == DIV_LAST) begin
        div_nxt   = '0;
        level_nxt = level + 1'b1;
      end else begin
        div_nxt   = div + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
